// File: rtl/pixel_write_queue.sv
// -----------------------------------------------------------------------------
// pixel_write_queue
//
// Downstream stage of the line-drawing engine. Plot requests (x, y, colour)
// arrive over a valid/ready handshake and are buffered in a small FIFO. Each
// cycle the framebuffer is not stalling, the head entry is popped into a set of
// output registers. This produces a one-cycle write strobe with a linear
// framebuffer address. The FIFO decouples the line engine from framebuffer
// stalls. Screen geometry is SCREEN_W x SCREEN_H, which is 320x240 by default.
//
// Optional feature macro: PIXEL_CLIP_EN
//   When it is defined, a request outside the screen is still handshaked but is
//   discarded instead of being queued. The extra output clip_drop pulses for
//   one cycle after each discarded request.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   in_valid    in   plot request present
//   in_ready    out  queue can accept (= not full; ignores a same-cycle pop)
//   in_x        in   [8:0]  pixel column
//   in_y        in   [7:0]  pixel row
//   in_colour   in   [COLOUR_W-1:0] pixel colour
//   out_stall   in   framebuffer busy; blocks pops
//   vga_plot    out  one-cycle write enable, one pulse per written pixel
//   vga_x       out  [8:0]  registered x of the current write
//   vga_y       out  [7:0]  registered y of the current write
//   vga_colour  out  [COLOUR_W-1:0] registered colour
//   vga_addr    out  [16:0] registered y*SCREEN_W + x (modulo 2^17)
//   count       out  [$clog2(DEPTH):0] FIFO occupancy, 0..DEPTH
//   idle        out  queue empty and no write in flight
//   clip_drop   out  (PIXEL_CLIP_EN only) request was discarded by the clip
// -----------------------------------------------------------------------------
module pixel_write_queue #(
   parameter int unsigned DEPTH    = 8,    // power of two, >= 2
   parameter int unsigned COLOUR_W = 1,
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8:0]              in_x,
   input  logic [7:0]              in_y,
   input  logic [COLOUR_W-1:0]     in_colour,
   input  logic                    out_stall,
   output logic                    vga_plot,
   output logic [8:0]              vga_x,
   output logic [7:0]              vga_y,
   output logic [COLOUR_W-1:0]     vga_colour,
   output logic [16:0]             vga_addr,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    idle
`ifdef PIXEL_CLIP_EN
   ,
   output logic                    clip_drop
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [8:0]          x;
      logic [7:0]          y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

   // ---------------------------------------------------------------------------
   // Storage and control state
   // ---------------------------------------------------------------------------
   pixel_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic               vga_plot_q,   vga_plot_d;
   logic [8:0]         vga_x_q,      vga_x_d;
   logic [7:0]         vga_y_q,      vga_y_d;
   logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
   logic [16:0]        vga_addr_q,   vga_addr_d;

   logic               full;
   logic               empty;
   logic               push_acc;   // handshake completes this cycle
   logic               push;       // entry is actually written into the FIFO
   logic               pop;
   pixel_t             head;
   pixel_t             in_pixel;
   logic [16:0]        head_addr;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign push_acc = in_valid && !full;
   assign pop      = !empty && !out_stall;

   assign in_pixel = '{x: in_x, y: in_y, colour: in_colour};
   assign head     = mem_q[rd_ptr_q];

   // Linear framebuffer address of the head entry. Truncation to 17 bits gives
   // the modulo-2^17 behaviour for out-of-range coordinates.
   assign head_addr = 17'(head.y) * 17'(SCREEN_W) + 17'(head.x);

`ifdef PIXEL_CLIP_EN
   logic in_range;
   logic clip_drop_q, clip_drop_d;

   assign in_range    = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
   assign push        = push_acc && in_range;
   assign clip_drop_d = push_acc && !in_range;
   assign clip_drop   = clip_drop_q;
`else
   assign push = push_acc;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic for pointers, occupancy and the write-port registers
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a value unassigned and no latch can be inferred.
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      vga_plot_d   = 1'b0;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_addr_d   = vga_addr_q;

      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      // A simultaneous push and pop leaves the occupancy unchanged.
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Pop loads the head into the write-port registers; otherwise they hold.
      if (pop) begin
         vga_plot_d   = 1'b1;
         vga_x_d      = head.x;
         vga_y_d      = head.y;
         vga_colour_d = head.colour;
         vga_addr_d   = head_addr;
      end
   end

   // ---------------------------------------------------------------------------
   // Control and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state is updated only with non-blocking assignments, so
      // every register samples the pre-edge value of every other register.
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         vga_plot_q   <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_addr_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         vga_plot_q   <= vga_plot_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_addr_q   <= vga_addr_d;
      end
   end

`ifdef PIXEL_CLIP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) clip_drop_q <= 1'b0;
      else       clip_drop_q <= clip_drop_d;
   end
`endif

   // NOTE: the FIFO storage has no reset. Entries are only read once count says
   // they were written, so clearing the pointers and count empties the queue.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_pixel;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign vga_plot   = vga_plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_addr   = vga_addr_q;
   assign count      = count_q;
   assign idle       = empty && !vga_plot_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_queue
//
// Directed testbench for pixel_write_queue with the default DEPTH=8,
// COLOUR_W=1 and 320x240 geometry. The scenarios are single pixel, stalled
// burst, streaming, full with simultaneous pop, mid-operation reset and
// off-screen coordinates. A negedge monitor records every write pulse so that
// order and content can be compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pixel_write_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  in_x = '0;
   logic [7:0]  in_y = '0;
   logic [0:0]  in_colour = '0;
   logic        out_stall = 1'b0;
   logic        vga_plot;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [0:0]  vga_colour;
   logic [16:0] vga_addr;
   logic [3:0]  count;
   logic        idle;
`ifdef PIXEL_CLIP_EN
   logic        clip_drop;
`endif

   pixel_write_queue dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .out_stall  (out_stall),
      .vga_plot   (vga_plot),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_addr   (vga_addr),
      .count      (count),
      .idle       (idle)
`ifdef PIXEL_CLIP_EN
      ,
      .clip_drop  (clip_drop)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [0:0]  c;
      logic [16:0] a;
   } wr_t;

   wr_t wq[$];
   int  clip_cnt = 0;
   int  total = 0;
   int  bad = 0;

   // Records every write pulse, sampled half a cycle away from the active edge.
   always @(negedge clk) begin
      if (vga_plot === 1'b1) wq.push_back('{x: vga_x, y: vga_y, c: vga_colour, a: vga_addr});
`ifdef PIXEL_CLIP_EN
      if (clip_drop === 1'b1) clip_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; all driving and sampling
   // happens there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int acc;
   int errs;
   int maxc;

   initial begin
      // ---------------- reset state ----------------
      #1 reset = 1'b1;
      #1;
      check("rst_count",    32'(count),    0);
      check("rst_plot",     32'(vga_plot), 0);
      check("rst_ready",    32'(in_ready), 1);
      check("rst_idle",     32'(idle),     1);
      check("rst_addr",     32'(vga_addr), 0);
      check("rst_xy",       32'({vga_x, vga_y, vga_colour}), 0);
      tick();
      tick();
      reset = 1'b0;

      // ---------------- 1: single pixel ----------------
      in_valid = 1'b1; in_x = 9'd5; in_y = 8'd3; in_colour = 1'b1;
      tick();                                   // edge N: accepted
      in_valid = 1'b0;
      check("t1_count_after_push", 32'(count),    1);
      check("t1_no_bypass",        32'(vga_plot), 0);
      tick();                                   // edge N+1: popped
      check("t1_plot",   32'(vga_plot),   1);
      check("t1_addr",   32'(vga_addr),   965);
      check("t1_xyc",    32'({vga_x, vga_y, vga_colour}), 32'({9'd5, 8'd3, 1'b1}));
      check("t1_busy",   32'(idle),       0);
      tick();
      check("t1_plot_off", 32'(vga_plot), 0);
      check("t1_idle",     32'(idle),     1);
      check("t1_addr_hold", 32'(vga_addr), 965);

      // ---------------- 2: stalled burst of 12 ----------------
      out_stall = 1'b1;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_x = 9'(10 + i); in_y = 8'(i); in_colour = 1'(i);
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      check("t2_accepted",  32'(acc),      8);
      check("t2_ready_low", 32'(in_ready), 0);
      check("t2_count",     32'(count),    8);
      check("t2_no_plot",   32'(vga_plot), 0);
      wq.delete();
      out_stall = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t2_drain_order", 32'({vga_plot, vga_x}), 32'({1'b1, 9'(10 + k)}));
      end
      check("t2_count_empty", 32'(count), 0);
      tick();
      check("t2_plot_off", 32'(vga_plot), 0);
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; in_x = 9'(18 + j); in_y = 8'(8 + j); in_colour = 1'(j);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("t2_write_total", 32'(wq.size()), 12);
      errs = 0;
      if (wq.size() == 12) begin
         for (int k = 0; k < 12; k++)
            if (wq[k].x !== 9'(10 + k) || wq[k].y !== 8'(k) || wq[k].c !== 1'(k) ||
                wq[k].a !== 17'(k * 320 + 10 + k))
               errs++;
      end else errs = 1;
      check("t2_content", 32'(errs), 0);

      // ---------------- 3: streaming 3*DEPTH entries ----------------
      wq.delete();
      maxc = 0;
      errs = 0;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         in_valid = 1'b1; in_x = 9'(i * 13); in_y = 8'(i * 10); in_colour = 1'(i);
         if (in_ready !== 1'b1) errs++;
         tick();
         if (int'(count) > maxc) maxc = int'(count);
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("t3_ready_always", 32'(errs),       0);
      check("t3_maxcount",     32'(maxc),       1);
      check("t3_writes",       32'(wq.size()),  24);
      errs = 0;
      if (wq.size() == 24) begin
         for (int k = 0; k < 24; k++)
            if (wq[k].x !== 9'(k * 13) || wq[k].y !== 8'(k * 10) ||
                wq[k].a !== 17'(k * 10 * 320 + k * 13))
               errs++;
      end else errs = 1;
      check("t3_content", 32'(errs), 0);

      // ---------------- 4: full with push and pop together ----------------
      wq.delete();
      out_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_x = 9'(100 + i); in_y = 8'd1; in_colour = 1'b1;
         tick();
      end
      in_valid = 1'b1; in_x = 9'd200; in_y = 8'd2; in_colour = 1'b0;
      check("t4_full_count", 32'(count),    8);
      check("t4_full_ready", 32'(in_ready), 0);
      out_stall = 1'b0;
      tick();                                   // pop only; push refused
      check("t4_count_dec", 32'(count),    7);
      check("t4_pop_head",  32'({vga_plot, vga_x}), 32'({1'b1, 9'd100}));
      check("t4_ready_up",  32'(in_ready), 1);
      tick();                                   // push accepted with pop
      check("t4_count_hold", 32'(count), 7);
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t4_writes", 32'(wq.size()), 9);
      errs = 0;
      if (wq.size() == 9) begin
         for (int k = 0; k < 8; k++)
            if (wq[k].x !== 9'(100 + k) || wq[k].a !== 17'(320 + 100 + k)) errs++;
         if (wq[8].x !== 9'd200 || wq[8].a !== 17'd840) errs++;
      end else errs = 1;
      check("t4_content", 32'(errs), 0);

      // ---------------- 5: reset mid-operation ----------------
      wq.delete();
      out_stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_x = 9'(50 + i); in_y = 8'd5; in_colour = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      out_stall = 1'b0;
      tick();
      check("t5_pending_count", 32'(count),    5);
      check("t5_pending_plot",  32'(vga_plot), 1);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_plot",  32'(vga_plot), 0);
      check("t5_rst_count", 32'(count),    0);
      check("t5_rst_idle",  32'(idle),     1);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t5_no_stale",   32'(wq.size()), 0);
      check("t5_count_zero", 32'(count),     0);
      check("t5_addr_reset", 32'(vga_addr),  0);

      // ---------------- 6: off-screen coordinates ----------------
      wq.delete();
      clip_cnt = 0;
      in_valid = 1'b1; in_x = 9'd320; in_y = 8'd0;   in_colour = 1'b1;
      tick();
`ifdef PIXEL_CLIP_EN
      check("t6_clip_a", 32'(clip_drop), 1);
`endif
      in_x = 9'd0;   in_y = 8'd240;
      tick();
`ifdef PIXEL_CLIP_EN
      check("t6_clip_b", 32'(clip_drop), 1);
`endif
      in_x = 9'd319; in_y = 8'd239;
      tick();
`ifdef PIXEL_CLIP_EN
      check("t6_clip_c", 32'(clip_drop), 0);
`endif
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
`ifdef PIXEL_CLIP_EN
      check("t6_clip_pulses", 32'(clip_cnt),  2);
      check("t6_writes",      32'(wq.size()), 1);
      if (wq.size() >= 1) check("t6_addr_max", 32'(wq[0].a), 76799);
`else
      check("t6_writes", 32'(wq.size()), 3);
      if (wq.size() == 3) begin
         check("t6_addr_x320", 32'(wq[0].a), 320);
         check("t6_addr_y240", 32'(wq[1].a), 76800);
         check("t6_addr_max",  32'(wq[2].a), 76799);
      end
`endif
      check("t6_idle", 32'(idle), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
